// File: rtl/bcd_feeder.sv
// bcd_feeder: binary-to-BCD converter feeding an eight-digit display.
// Optional feature: define BCD_FEEDER_SATURATE_EN to clamp overflows to 99_999_999.
module bcd_feeder #(
    parameter int WIDTH = 27
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] value,
    output logic [3:0]       pos,
    output logic [3:0]       dig,
    output logic             done,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        EMIT
    } state_t;

    localparam logic [31:0] MAXDEC   = 32'd99_999_999;
    localparam logic [5:0]  CNT_INIT = 6'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [31:0]      bcd_q, bcd_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [2:0]       idx_n;
    logic             in_ready_d;
    logic [3:0]       pos_d, dig_d;
    logic             done_d, ovf_d;

    logic [32:0]      vext;
    logic             ovf_in;
    logic [WIDTH-1:0] load_val;
    logic [31:0]      adj;
    logic [31:0]      bcd_shift;

    function automatic logic [3:0] nib(input logic [31:0] w, input logic [2:0] i);
        nib = w[{i, 2'b00} +: 4];
    endfunction

    assign vext   = 33'(value);
    assign ovf_in = (WIDTH >= 27) && (vext > 33'(MAXDEC));
    assign idx_n  = idx_q + 3'd1;

`ifdef BCD_FEEDER_SATURATE_EN
    assign load_val = ovf_in ? MAXDEC[WIDTH-1:0] : value;
`else
    assign load_val = value;
`endif

    // one double-dabble step: add 3 to every nibble >= 5, then shift in next bit
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 8; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        bcd_shift = {adj[30:0], shreg_q[WIDTH-1]};
    end

    // next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        in_ready_d = in_ready;
        pos_d      = pos;
        dig_d      = dig;
        done_d     = 1'b0;
        ovf_d      = overflow;
        unique case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                pos_d      = 4'hF;
                dig_d      = 4'hF;
                if (in_valid && in_ready) begin
                    shreg_d    = load_val;
                    bcd_d      = 32'd0;
                    ovf_d      = ovf_in;
                    cnt_d      = CNT_INIT;
                    state_d    = CONV;
                    in_ready_d = 1'b0;
                end
            end
            CONV: begin
                bcd_d   = bcd_shift;
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = EMIT;
                    idx_d   = 3'd0;
                    pos_d   = 4'd0;
                    dig_d   = bcd_shift[3:0];
                end
            end
            EMIT: begin
                if (idx_q == 3'd7) begin
                    state_d    = IDLE;
                    pos_d      = 4'hF;
                    dig_d      = 4'hF;
                    in_ready_d = 1'b1;
                end else begin
                    idx_d  = idx_n;
                    pos_d  = {1'b0, idx_n};
                    dig_d  = nib(bcd_q, idx_n);
                    done_d = (idx_n == 3'd7);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state, datapath and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            in_ready <= 1'b1;
            pos      <= 4'hF;
            dig      <= 4'hF;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            in_ready <= in_ready_d;
            pos      <= pos_d;
            dig      <= dig_d;
            done     <= done_d;
            overflow <= ovf_d;
        end
    end

endmodule

// File: doc/bcd_feeder.md
# bcd_feeder

Upstream stage of the eight-digit seven-segment controller. Accepts a binary value over a valid/ready handshake, converts it to eight BCD digits with a sequential double-dabble engine, then emits one digit per cycle as a `(pos, dig)` write pair. The downstream controller latches `dig` into display `pos` whenever `pos < 8` and `dig < 10`. Between bursts this block parks `pos` and `dig` at invalid codes, so no write occurs.

## Interface
Parameters:
- `WIDTH`, default 27: binary input width; legal range 4..32. 27 bits covers 99_999_999.

Ports:
- `clock`  in  1: system clock.
- `reset`  in  1: asynchronous, active-low.
- `in_valid`  in  1: `value` is presented.
- `in_ready`  out  1: block is idle and accepts a value.
- `value`  in  WIDTH: unsigned binary number to display.
- `pos`  out  4: target display index, 0 = units digit; 4'hF when idle.
- `dig`  out  4: BCD digit 0..9; 4'hF when idle.
- `done`  out  1: one-cycle pulse coincident with the `pos = 7` write.
- `overflow`  out  1: the last accepted `value` exceeded 99_999_999. Held until the next accept.

## Operation
- FSM states: IDLE, CONV, EMIT.
- IDLE
  - `in_ready = 1`; `pos = 4'hF`; `dig = 4'hF`.
  - On `in_valid & in_ready`:
    - Capture `value` (or 99_999_999, see Configuration) into the shift register.
    - Clear the 32-bit BCD accumulator.
    - Set `overflow = (value > 99_999_999)`.
    - Load bit counter = WIDTH; go to CONV.
- CONV, one bit per cycle for WIDTH cycles:
  - Every BCD nibble >= 5 gets +3.
  - Then `{bcd, shreg}` shifts left by 1.
  - Counter decrements.
  - On the last bit, go to EMIT with digit index = 0.
  - Bits carried out of the top nibble are discarded, so the result is `value mod 10^8`.
- EMIT, 8 cycles:
  - `pos` = index; `dig` = nibble[index] of the accumulator.
  - Index increments 0..7.
  - At index 7, `done = 1`; next state is IDLE.
- `in_valid` while not in IDLE is ignored. The value is not queued; the upstream holds it until `in_ready`.
- When `WIDTH < 27`, `overflow` is constant 0.
- All outputs are registered; no combinational path from inputs to outputs.

## Timing
- Reset values:
  - `in_ready = 1`, `pos = 4'hF`, `dig = 4'hF`, `done = 0`, `overflow = 0`.
  - State = IDLE; accumulator, shift register and counters = 0.
- Handshake in cycle T. CONV occupies T+1..T+WIDTH.
- Digit k appears on `pos`/`dig` in cycle T+WIDTH+1+k, for k = 0..7.
- `done` is high in cycle T+WIDTH+8.
- `in_ready` rises in cycle T+WIDTH+9. The earliest next accept is that cycle.
- Throughput: one value per WIDTH+9 cycles (36 for WIDTH = 27).
- `in_ready` falls in cycle T+1 and stays low through the final EMIT cycle.
- `overflow` updates in cycle T+1.
- Reset asserted mid-CONV or mid-EMIT:
  - Outputs take reset values immediately.
  - The remaining digits are not written; digits already written stay in the downstream buffer.
  - After release, the block waits in IDLE.

## Configuration
- Macro `BCD_FEEDER_SATURATE_EN`.
- Defined: on accept with `value > 99_999_999`, the shift register is loaded with 99_999_999, so all eight displays show 9.
- Undefined: the raw value is loaded and the display shows `value mod 10^8`.
- `overflow` is reported identically in both builds.

## Test plan
- WIDTH = 27, `value` = 12_345_678 accepted at T → cycles T+28..T+35 emit (pos, dig) = (0,8)(1,7)(2,6)(3,5)(4,4)(5,3)(6,2)(7,1). `done` high at T+35, `in_ready` high at T+36, `overflow` = 0.
- `value` = 0 → eight writes of `dig` = 0 at `pos` 0..7. Idle cycles before and after show `pos` = `dig` = 4'hF.
- `value` = 134_217_727:
  - With the macro: all eight digits are 9, `overflow` = 1.
  - Without the macro: digits 7,2,7,7,1,2,4,3 at `pos` 0..7, `overflow` = 1.
- `in_valid` held high with a new `value` of 555 throughout a burst → the second value is accepted only in the cycle `in_ready` returns. No emitted digit of the first burst is corrupted.
- Reset pulsed low during EMIT at index 3 → `pos` = 4'hF and `dig` = 4'hF in the same cycle, no further writes, `done` never pulses, `in_ready` = 1 after release. A following accept of 42 emits 2,4,0,0,0,0,0,0.
- Back-to-back accepts of 99_999_999 and then 1 → the second burst starts exactly WIDTH+9 cycles after the first handshake. `overflow` = 0 after the second accept.
